// File: rtl/display_source.sv
// display_source: BCD time-of-day clock with a stored six-digit word and a
// periodic display-select toggle.
//
// Configuration macro: TWELVE_HOUR_EN
//   undefined -> 24-hour clock, hours 00-23, reset time 00:00:00
//   defined   -> 12-hour clock, hours 01-12, reset time 12:00:00
//
// Parameters:
//   CLK_HZ   - clk cycles per second tick (>= 2)
//   ALT_SECS - seconds between toggles of b (1..255)
//
// Ports:
//   clk     in   clock, all state changes on rising edge
//   rst_n   in   asynchronous active-low reset
//   set_en  in   load time from set_val (ignored if set_val is not a legal time)
//   set_val in   BCD hh:mm:ss, [23:20]=H tens .. [3:0]=S units
//   mem_we  in   write mem_val into the stored word
//   mem_val in   six BCD digits, stored unchecked
//   a1      out  current time, BCD, same layout as set_val
//   a2      out  stored word
//   b       out  display select (0 -> a1, 1 -> a2)
//   tick    out  one-cycle pulse on each second boundary
module display_source #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned ALT_SECS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en,
    input  logic [23:0] set_val,
    input  logic        mem_we,
    input  logic [23:0] mem_val,
    output logic [23:0] a1,
    output logic [23:0] a2,
    output logic        b,
    output logic        tick
);

    localparam int unsigned    CW      = $clog2(CLK_HZ);
    localparam logic [CW-1:0] PRE_MAX = CW'(CLK_HZ - 1);
    localparam logic [7:0]    ALT_MAX = 8'(ALT_SECS - 1);

`ifdef TWELVE_HOUR_EN
    localparam logic [23:0] TIME_RST  = 24'h120000;
    localparam logic [7:0]  HOUR_LAST = 8'h12;
    localparam logic [7:0]  HOUR_FIRST = 8'h01;
`else
    localparam logic [23:0] TIME_RST  = 24'h000000;
    localparam logic [7:0]  HOUR_LAST = 8'h23;
    localparam logic [7:0]  HOUR_FIRST = 8'h00;
`endif

    logic [CW-1:0] pre_q, pre_d;
    logic [7:0]    alt_q, alt_d;
    logic [23:0]   time_q, time_d;
    logic [23:0]   mem_q, mem_d;
    logic          b_q, b_d;
    logic          tick_q, tick_d;

    // Two-digit BCD increment; callers handle the wrap value themselves.
    function automatic logic [7:0] inc_bcd(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic       digits_ok;
    logic       hour_ok;
    logic       set_ok;
    logic       wrap;
    logic [7:0] sec_cur, min_cur, hour_cur;
    logic [7:0] sec_nxt, min_nxt, hour_nxt;
    logic [23:0] time_inc;

    // Legality of set_val
    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (set_val[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
`ifdef TWELVE_HOUR_EN
        hour_ok = ((set_val[23:20] == 4'd0) && (set_val[19:16] != 4'd0)) ||
                  ((set_val[23:20] == 4'd1) && (set_val[19:16] <= 4'd2));
`else
        hour_ok = (set_val[23:20] < 4'd2) ||
                  ((set_val[23:20] == 4'd2) && (set_val[19:16] <= 4'd3));
`endif
        set_ok = set_en && digits_ok && hour_ok &&
                 (set_val[15:12] <= 4'd5) && (set_val[7:4] <= 4'd5);
    end

    // Time + 1 second with BCD carries
    always_comb begin
        sec_cur  = time_q[7:0];
        min_cur  = time_q[15:8];
        hour_cur = time_q[23:16];
        sec_nxt  = (sec_cur == 8'h59) ? 8'h00 : inc_bcd(sec_cur);
        min_nxt  = min_cur;
        hour_nxt = hour_cur;
        if (sec_cur == 8'h59) begin
            min_nxt = (min_cur == 8'h59) ? 8'h00 : inc_bcd(min_cur);
            if (min_cur == 8'h59) begin
                hour_nxt = (hour_cur == HOUR_LAST) ? HOUR_FIRST : inc_bcd(hour_cur);
            end
        end
        time_inc = {hour_nxt, min_nxt, sec_nxt};
    end

    // Next state
    always_comb begin
        wrap   = (pre_q == PRE_MAX);
        pre_d  = wrap ? '0 : pre_q + 1'b1;
        time_d = time_q;
        alt_d  = alt_q;
        b_d    = b_q;
        tick_d = wrap;
        mem_d  = mem_we ? mem_val : mem_q;

        if (set_ok) begin
            // A valid set restarts the second and suppresses a coincident tick.
            pre_d  = '0;
            time_d = set_val;
            alt_d  = 8'd0;
            tick_d = 1'b0;
        end else if (wrap) begin
            time_d = time_inc;
            if (alt_q == ALT_MAX) begin
                alt_d = 8'd0;
                b_d   = ~b_q;
            end else begin
                alt_d = alt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            alt_q  <= 8'd0;
            time_q <= TIME_RST;
            mem_q  <= 24'h000000;
            b_q    <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            alt_q  <= alt_d;
            time_q <= time_d;
            mem_q  <= mem_d;
            b_q    <= b_d;
            tick_q <= tick_d;
        end
    end

    assign a1   = time_q;
    assign a2   = mem_q;
    assign b    = b_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_display_source.sv
// Testbench for display_source (CLK_HZ=4, ALT_SECS=2). Expected outputs come
// from a seconds-of-day reference model and flow through a scoreboard queue
// to a monitor that compares on every falling clock edge.
module tb_display_source;

    localparam int unsigned CLK_HZ   = 4;
    localparam int unsigned ALT_SECS = 2;

`ifdef TWELVE_HOUR_EN
    localparam int          DAY    = 43200;
    localparam logic [23:0] RST_A1 = 24'h120000;
`else
    localparam int          DAY    = 86400;
    localparam logic [23:0] RST_A1 = 24'h000000;
`endif

    typedef struct packed {
        logic [23:0] a1;
        logic [23:0] a2;
        logic        b;
        logic        tick;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        set_en;
    logic [23:0] set_val;
    logic        mem_we;
    logic [23:0] mem_val;
    logic [23:0] a1;
    logic [23:0] a2;
    logic        b;
    logic        tick;

    display_source #(
        .CLK_HZ  (CLK_HZ),
        .ALT_SECS(ALT_SECS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (set_en),
        .set_val(set_val),
        .mem_we (mem_we),
        .mem_val(mem_val),
        .a1     (a1),
        .a2     (a2),
        .b      (b),
        .tick   (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    // Reference model state
    int          m_t;
    int          m_phase;
    int          m_alt;
    logic        m_b;
    logic        m_tick;
    logic [23:0] m_a2;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dig2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [23:0] t_to_bcd(input int t);
        int h;
        h = t / 3600;
`ifdef TWELVE_HOUR_EN
        if (h == 0) h = 12;
`endif
        return {dig2(h), dig2((t / 60) % 60), dig2(t % 60)};
    endfunction

    function automatic bit model_valid(input logic [23:0] v);
        int h, mi, s;
        for (int i = 0; i < 6; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        h  = int'(v[23:20]) * 10 + int'(v[19:16]);
        mi = int'(v[15:12]) * 10 + int'(v[11:8]);
        s  = int'(v[7:4]) * 10 + int'(v[3:0]);
        if (mi > 59 || s > 59) return 1'b0;
`ifdef TWELVE_HOUR_EN
        return (h >= 1 && h <= 12);
`else
        return (h <= 23);
`endif
    endfunction

    function automatic int bcd_to_t(input logic [23:0] v);
        int h;
        h = int'(v[23:20]) * 10 + int'(v[19:16]);
        return (h % 24 % (DAY / 3600)) * 3600 +
               (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
               int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic model_reset();
        m_t = 0; m_phase = 0; m_alt = 0; m_b = 1'b0; m_tick = 1'b0; m_a2 = 24'h0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.a1 = t_to_bcd(m_t); e.a2 = m_a2; e.b = m_b; e.tick = m_tick;
        return e;
    endfunction

    // One clock cycle: drive inputs, advance model, push expectation after the edge.
    task automatic step(input logic se, input logic [23:0] sv,
                        input logic mw, input logic [23:0] mv);
        bit do_set;
        set_en = se; set_val = sv; mem_we = mw; mem_val = mv;
        do_set = se && model_valid(sv);
        if (do_set) begin
            m_t = bcd_to_t(sv); m_phase = 0; m_alt = 0; m_tick = 1'b0;
        end else if (m_phase == CLK_HZ - 1) begin
            m_phase = 0; m_tick = 1'b1;
            m_t = (m_t + 1) % DAY;
            m_alt++;
            if (m_alt == ALT_SECS) begin
                m_alt = 0; m_b = ~m_b;
            end
        end else begin
            m_phase++; m_tick = 1'b0;
        end
        if (mw) m_a2 = mv;
        @(posedge clk);
        sb_q.push_back(model_out());
        #1;
        set_en = 1'b0; mem_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, 1'b0, 24'h0);
    endtask

    // Cycles held in reset: outputs must stay at reset values.
    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            sb_q.push_back(model_out());
            #1;
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations on falling edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("a1", a1, e.a1);
                chk("a2", a2, e.a2);
                chk("b", {23'd0, b}, {23'd0, e.b});
                chk("tick", {23'd0, tick}, {23'd0, e.tick});
            end
        end
    end

    initial begin
        int          ticks;
        logic [23:0] v;
        rst_n = 1'b0; set_en = 1'b0; set_val = 24'h0; mem_we = 1'b0; mem_val = 24'h0;
        model_reset();
        #1;
        chk("reset_a1", a1, RST_A1);
        chk("reset_a2", a2, 24'h0);
        chk("reset_b_tick", {22'd0, b, tick}, 24'd0);
        reset_cycles(2);
        rst_n = 1'b1;

        // 16 cycles from reset: 4 ticks, b toggles twice back to 0
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1);
            if (tick) ticks++;
        end
        chk("run16_ticks", 24'(ticks), 24'd4);
        chk("run16_a1", a1, RST_A1 | 24'h000004);
        chk("run16_b", {23'd0, b}, 24'd0);

        // Rollover at end of day
`ifdef TWELVE_HOUR_EN
        step(1'b1, 24'h125959, 1'b0, 24'h0);
        idle(4);
        chk("rollover", a1, 24'h010000);
`else
        step(1'b1, 24'h235958, 1'b0, 24'h0);
        idle(4);
        chk("rollover_1", a1, 24'h235959);
        idle(4);
        chk("rollover_2", a1, 24'h000000);
`endif

        // Invalid sets ignored
        idle(1);
        v = a1;
        step(1'b1, 24'h236000, 1'b0, 24'h0);
        step(1'b1, 24'h1A0000, 1'b0, 24'h0);
        chk("invalid_set_a1", a1, v);
        idle(4);

        // Set coinciding with prescaler wrap
        for (int i = 0; i < 8 && m_phase != CLK_HZ - 1; i++) idle(1);
        step(1'b1, 24'h101010, 1'b0, 24'h0);
        chk("set_wrap_tick", {23'd0, tick}, 24'd0);
        chk("set_wrap_a1", a1, 24'h101010);
        idle(3);
        chk("set_wrap_no_early", {23'd0, tick}, 24'd0);
        idle(1);
        chk("set_wrap_tick4", {23'd0, tick}, 24'd1);

        // Simultaneous set and memory write
        step(1'b1, 24'h120000, 1'b1, 24'h140399);
        chk("both_a2", a2, 24'h140399);
        chk("both_a1", a1, 24'h120000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        se, mw;
            logic [23:0] sv, mv;
            se = ($urandom_range(0, 15) == 0);
            sv = ($urandom_range(0, 1) == 0) ? t_to_bcd($urandom_range(0, DAY - 1))
                                             : 24'($urandom);
            mw = ($urandom_range(0, 7) == 0);
            mv = 24'($urandom);
            step(se, sv, mw, mv);
        end

        // Asynchronous reset mid-count
        step(1'b1, 24'h000017, 1'b1, 24'h654321);
        idle(2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a1", a1, RST_A1);
        chk("async_rst_a2", a2, 24'h0);
        chk("async_rst_b_tick", {22'd0, b, tick}, 24'd0);
        model_reset();
        reset_cycles(1);
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_no_tick", {23'd0, tick}, 24'd0);
        idle(1);
        chk("post_rst_tick4", {23'd0, tick}, 24'd1);
        idle(8);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 24'(sb_q.size()), 24'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_source.md
DISPLAY_SOURCE -- requirements
Module: display_source

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning clk cycles per second tick (legal range 2 and up).
REQ-002 The block SHALL have parameter ALT_SECS, default 4, meaning seconds between toggles of b (legal range 1 to 255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port set_en, input, 1 bit: load the time from set_val this cycle.
REQ-006 The block SHALL have port set_val, input, 24 bits: BCD time hh:mm:ss, laid out as [23:20]=H tens down to [3:0]=S units.
REQ-007 The block SHALL have port mem_we, input, 1 bit: write mem_val into the stored word.
REQ-008 The block SHALL have port mem_val, input, 24 bits: six BCD digits, for example a date ddmmyy.
REQ-009 The block SHALL have port a1, output, 24 bits: current time in BCD, same digit layout as set_val.
REQ-010 The block SHALL have port a2, output, 24 bits: the stored word.
REQ-011 The block SHALL have port b, output, 1 bit: display select, 0 shows a1 and 1 shows a2.
REQ-012 The block SHALL have port tick, output, 1 bit: a one-cycle pulse on each second boundary.

Function
REQ-013 The prescaler SHALL count 0 to CLK_HZ-1 and wrap to 0; tick SHALL be 1 in the cycle after the prescaler holds CLK_HZ-1.
REQ-014 On each tick, seconds SHALL advance 00-59, carry into minutes 00-59, then carry into hours, all in BCD with every digit kept 0-9.
REQ-015 The hours range SHALL be 00-23; 23:59:59 plus a tick SHALL give 00:00:00.
REQ-016 All outputs SHALL be registered; a1 SHALL show the new time in the same cycle that tick is high.
REQ-017 set_en=1 with valid set_val SHALL load the time and clear the prescaler to 0; a1 SHALL equal set_val on the next cycle.
REQ-018 Validity SHALL mean: every digit 0-9, seconds tens 0-5, minutes tens 0-5, and the hour inside the hours range.
REQ-019 set_en=1 with invalid set_val SHALL be ignored: time and prescaler unchanged.
REQ-020 When set_en (valid) coincides with a prescaler wrap, the set SHALL win: no increment, and tick SHALL be 0 in the next cycle.
REQ-021 mem_we=1 SHALL update a2 to mem_val on the next cycle, with no validity check; last write wins.
REQ-022 Alternation counter: on each tick it SHALL count 0 to ALT_SECS-1; on wrap, b SHALL invert in the same cycle that tick is high.
REQ-023 A valid set SHALL clear the alternation counter and leave b unchanged.
REQ-024 set_en and mem_we SHALL be independent; both high in the same cycle SHALL perform both actions.

Reset
REQ-025 rst_n=0 SHALL immediately force: prescaler=0, alternation counter=0, a1=000000 (or 120000 per REQ-027), a2=000000, b=0, tick=0.
REQ-026 Reset in the middle of counting SHALL discard the partial second; counting SHALL restart on the first clk edge after rst_n rises.

Configuration
REQ-027 The macro TWELVE_HOUR_EN SHALL select the hours format.
- Defined: hours range 01-12; 12:59:59 plus a tick gives 01:00:00; reset value of a1 is 120000; hour 00 or above 12 is invalid for set.
- Undefined: 24-hour behaviour per REQ-015, reset value 000000.
- The port list SHALL be identical in both builds.

Verification (CLK_HZ=4, ALT_SECS=2)
REQ-028 Release reset, run 16 cycles -> exactly 4 tick pulses, a1=000004, b toggled twice and back to 0.
REQ-029 Set 235958, run 8 cycles -> a1 goes 235959 then 000000 (with TWELVE_HOUR_EN: set 125959, one tick -> 010000).
REQ-030 set_en with 236000 or 1A0000 -> a1 unchanged, prescaler phase unchanged.
REQ-031 set_en asserted in the cycle the prescaler equals 3 -> no tick next cycle, a1=set_val, next tick 4 cycles later.
REQ-032 mem_we=1 with mem_val=140399, together with set_en=1, set_val=120000 -> a2=140399 and a1=120000 next cycle.
REQ-033 rst_n pulled low mid-count (prescaler=2, a1=000017) -> all outputs at reset values with no clk edge; first tick 4 cycles after release.
